conv_encoder: RTL and testbench



---
 rtl/conv_encoder.sv | 70 +++++++
 tb/tb_conv_encoder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=3 (7,5) serial convolutional encoder, one 8-bit message -> 16-bit code word.
// Optional CONV_ENC_ERRINJ_EN adds err_mask, XORed into the code word on its final encode edge.
module conv_encoder (
`ifdef CONV_ENC_ERRINJ_EN
  input  logic [15:0] err_mask,
`endif
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  msg,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic [15:0] code,
  output logic        code_valid,
  input  logic        code_ready,
  output logic        done_flag
);
  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
  state_t state;
  logic [7:0] msg_q;
  logic [2:0] cnt;
  logic s1, s2, u, c0, c1;
  logic [15:0] mask, shifted;
`ifdef CONV_ENC_ERRINJ_EN
  assign mask = err_mask;
`else
  assign mask = '0;
`endif
  assign u = msg_q[7];
  assign c0 = u ^ s1 ^ s2;
  assign c1 = u ^ s2;
  assign shifted = {code[13:0], c0, c1};
  assign msg_ready = state == IDLE;
  assign code_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      msg_q <= '0;
      cnt <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      code <= '0;
      done_flag <= 1'b0;
    end else if (en) begin
      done_flag <= 1'b0;
      case (state)
        IDLE: if (msg_valid) begin
          msg_q <= msg;
          cnt <= '0;
          s1 <= 1'b0;
          s2 <= 1'b0;
          state <= ENC;
        end
        ENC: begin
          code <= cnt == 3'd7 ? shifted ^ mask : shifted;
          s2 <= s1;
          s1 <= u;
          msg_q <= {msg_q[6:0], 1'b0};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= DONE;
            done_flag <= 1'b1;
          end
        end
        DONE: if (code_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed + randomized check of conv_encoder against a polynomial-level reference.
module tb_conv_encoder;
  logic clk = 0, rst_n = 0, en = 1, msg_valid = 0, code_ready = 0;
  logic [7:0] msg = 0;
  logic [15:0] code, err_mask = 0;
  logic msg_ready, code_valid, done_flag;
  int checks = 0, errors = 0;
  conv_encoder dut (
`ifdef CONV_ENC_ERRINJ_EN
    .err_mask(err_mask),
`endif
    .clk(clk), .rst_n(rst_n), .en(en), .msg(msg), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .code(code), .code_valid(code_valid),
    .code_ready(code_ready), .done_flag(done_flag)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Each output pair is the generator taps applied to the current bit and the two before it (zero before msg[7]).
  function automatic logic [15:0] encode(input logic [7:0] m);
    logic [15:0] r = 0;
    logic p1, p2;
    for (int i = 7; i >= 0; i--) begin
      p1 = i < 7 ? m[i+1] : 1'b0;
      p2 = i < 6 ? m[i+2] : 1'b0;
      r = {r[13:0], m[i] ^ p1 ^ p2, m[i] ^ p2};
    end
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [7:0] m);
    int n = 0;
    while (!msg_ready && n < 40) begin tick(); n++; end
    check("accept_ready", msg_ready, 1);
    msg = m;
    msg_valid = 1;
    tick();
    msg_valid = 0;
    msg = ~m;
  endtask
  task automatic run_word(input logic [7:0] m, input int hold, input bit gap, input logic [15:0] mask);
    int n = 0;
    logic [15:0] exp;
    `ifdef CONV_ENC_ERRINJ_EN
    exp = encode(m) ^ mask;
    `else
    exp = encode(m);
    `endif
    err_mask = mask;
    accept(m);
    while (!code_valid && n < 40) begin
      en = !(gap && n >= 2 && n < 5);
      tick();
      n++;
    end
    en = 1;
    check("latency", n, gap ? 11 : 8);
    check("code", code, exp);
    check("done_flag_rise", done_flag, 1);
    check("msg_ready_done", msg_ready, 0);
    if (hold > 0) begin
      en = 0;
      tick();
      check("done_flag_hold_en_low", done_flag, 1);
      en = 1;
    end
    for (int i = 0; i < hold; i++) begin
      msg_valid = 1;
      tick();
      check("done_flag_pulse", done_flag, 0);
      check("code_stable", code, exp);
      check("held_valid", code_valid, 1);
      check("held_not_ready", msg_ready, 0);
    end
    msg_valid = 0;
    code_ready = 1;
    tick();
    code_ready = 0;
    check("consumed_valid", code_valid, 0);
    check("consumed_ready", msg_ready, 1);
    check("consumed_done", done_flag, 0);
  endtask
  initial begin
    #12;
    check("rst_ready", msg_ready, 1);
    check("rst_code", code, 0);
    check("rst_valid", code_valid, 0);
    check("rst_done", done_flag, 0);
    rst_n = 1;
    tick();
    run_word(8'h80, 0, 0, 16'h0000);
    check("vec_80", code, 16'hEC00);
    run_word(8'hFF, 0, 0, 16'h0000);
    check("vec_ff", code, 16'hDAAA);
    run_word(8'h00, 0, 0, 16'h0000);
    check("vec_00", code, 16'h0000);
    run_word(8'hA5, 5, 0, 16'h0000);
    run_word(8'h80, 0, 1, 16'h0000);
    check("vec_80_gap", code, 16'hEC00);
    accept(8'hFF);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 0;
    #1;
    check("abort_ready", msg_ready, 1);
    check("abort_code", code, 0);
    check("abort_valid", code_valid, 0);
    check("abort_done", done_flag, 0);
    tick();
    rst_n = 1;
    tick();
    check("abort_no_done", done_flag, 0);
    run_word(8'hFF, 0, 0, 16'h0000);
    check("vec_ff_after_abort", code, 16'hDAAA);
    `ifdef CONV_ENC_ERRINJ_EN
    run_word(8'h80, 0, 0, 16'h0001);
    check("vec_errinj", code, 16'hEC01);
    `endif
    for (int k = 0; k < 25; k++)
      run_word(8'($urandom), $urandom_range(0, 3), 1'($urandom), 16'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
